multi_ticker: RTL
=================

// Module: multi_ticker
// PURPOSE
//  Multi-channel programmable tick generator; generalised successor to the fixed single-period ticker.
//  N_CH independent channels share one free-running prescaler strobe.
//  Each channel has a runtime period, a periodic/one-shot mode, and start/stop control.
//  Feeds per-channel single-cycle enable pulses to debouncers, display scanners, UART baud and timeouts.
// PARAMETERS
//  N_CH           4    number of channels (1..16)
//  WIDTH          16   period/counter width in bits; legal period 1..2^WIDTH-1
//  PRESCALE       1    clk cycles per internal strobe (>=1); 1 = strobe every cycle
//  DEFAULT_PERIOD 100  period loaded into every channel at reset (1..2^WIDTH-1)
// PORTS
//  clk         in   1               system clock, 100 MHz
//  rst         in   1               synchronous reset, active-high
//  en          in   1               global enable; low freezes prescaler and all counters
//  cfg_we      in   1               config write strobe
//  cfg_ch      in   $clog2(N_CH)    channel index for write (max(1,...) bits)
//  cfg_period  in   WIDTH           period value written
//  cfg_oneshot in   1               mode written: 1 = one-shot, 0 = periodic
//  start       in   N_CH            per-channel start pulse
//  stop        in   N_CH            per-channel stop pulse
//  tick        out  N_CH            registered single-cycle tick per channel
//  active      out  N_CH            channel running
// BEHAVIOUR
//  Reset: tick=0, active=0, counters=0, prescaler=0, period=DEFAULT_PERIOD, mode=periodic.
//  rst has priority over every other input.
//  Prescaler:
//   - counts 0..PRESCALE-1 while en=1; strobe asserted when it is at PRESCALE-1, then wraps to 0.
//   - free-running; not cleared by start.
//  Channel counter (active=1, en=1, strobe=1):
//   - count==period-1 -> tick<=1, count<=0.
//   - otherwise -> count<=count+1, tick<=0.
//  tick is 0 in every cycle not meeting the above, including en=0, active=0 and no strobe.
//  tick never stays high two consecutive cycles unless period=1 and PRESCALE=1.
//  Latency (PRESCALE=1): start sampled at edge k -> first tick high in the cycle after edge k+P, then every P cycles.
//  With PRESCALE>1, first-tick latency is (P-1)*PRESCALE+1 .. P*PRESCALE cycles.
//  start[i]: active<=1, count<=0; pending shadow period applied immediately.
//   - start while already active restarts the count.
//  stop[i]: active<=0, count<=0; a tick due in the same cycle is suppressed.
//  start[i] and stop[i] in the same cycle: stop wins.
//  One-shot: on the tick, active<=0 in the same edge; tick still pulses once.
//  Config write:
//   - cfg_period/cfg_oneshot go to channel cfg_ch shadow registers.
//   - Channel idle: shadow copied to live at the same edge.
//   - Channel active: live updated at the next wrap (tick edge) or next start, so the current period completes unaltered.
//   - Write of period 0 is ignored (live and shadow unchanged).
//   - cfg_ch >= N_CH is ignored.
//  Simultaneous cfg_we and wrap on the same channel: the wrap uses the old period; the new period governs the next cycle of counting.
//  en=0 mid-count: all state held; counting resumes exactly where it stopped when en returns high.
//  rst mid-operation: everything returns to reset values next edge; pending shadows discarded.
//  Counter arithmetic is WIDTH-bit unsigned; period=2^WIDTH-1 wraps to 0 without overflow.
// TESTING
//  1 Reset, start[0], PRESCALE=1, DEFAULT_PERIOD=100 -> tick[0] every 100 cycles, first 100 cycles after start edge.
//  2 Write ch1 period=3, oneshot=1, then start[1] -> one tick[1] 3 cycles later, active[1] falls with it, no further ticks.
//  3 ch0 active at period 10, write period=4 at count 5 -> next tick at the old 10-boundary, then every 4.
//  4 start[2] and stop[2] same cycle -> active[2] stays 0; stop on a wrap cycle -> no tick.
//  5 en low for 7 cycles mid-count, period 10 -> that tick delayed by exactly 7 cycles; no ticks while en=0.
//  6 PRESCALE=4, period=1, all channels started -> all tick together every 4 cycles; rst mid-run -> outputs 0 next cycle.

Source files
------------

// File: rtl/multi_ticker.sv
// Multi-channel programmable tick generator: one shared prescaler strobe drives
// N_CH independent period counters, each periodic or one-shot, with start/stop control.
module multi_ticker #(
    parameter int N_CH           = 4,
    parameter int WIDTH          = 16,
    parameter int PRESCALE       = 1,
    parameter int DEFAULT_PERIOD = 100,
    localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_oneshot,
    input  logic [N_CH-1:0]  start,
    input  logic [N_CH-1:0]  stop,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  active
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] DEF_P   = WIDTH'(DEFAULT_PERIOD);

    logic [PS_W-1:0] ps_q, ps_d;
    logic            strobe;

    always_comb begin
        strobe = (ps_q == PS_LAST);
        ps_d   = ps_q;
        if (en) begin
            ps_d = strobe ? '0 : ps_q + PS_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [WIDTH-1:0] count_q, count_d;
        logic [WIDTH-1:0] period_q, period_d;
        logic [WIDTH-1:0] sh_period_q, sh_period_d;
        logic             oneshot_q, oneshot_d;
        logic             sh_oneshot_q, sh_oneshot_d;
        logic             pend_q, pend_d;
        logic             active_q, active_d;
        logic             tick_q, tick_d;
        logic             wr, wrap, apply;

        // A write to a running channel parks in the shadow until the next wrap or
        // start, so the period in progress always completes with its old length.
        always_comb begin
            wr           = cfg_we && (cfg_ch == CH_W'(i)) && (cfg_period != '0);
            wrap         = active_q && en && strobe && (count_q == period_q - CNT_ONE);
            sh_period_d  = wr ? cfg_period : sh_period_q;
            sh_oneshot_d = wr ? cfg_oneshot : sh_oneshot_q;
            pend_d       = pend_q | wr;
            count_d      = count_q;
            active_d     = active_q;
            tick_d       = 1'b0;
            apply        = !active_q;
            period_d     = period_q;
            oneshot_d    = oneshot_q;

            if (stop[i]) begin
                active_d = 1'b0;
                count_d  = '0;
            end else if (start[i]) begin
                active_d = 1'b1;
                count_d  = '0;
                apply    = 1'b1;
            end else if (active_q && en && strobe) begin
                if (wrap) begin
                    tick_d  = 1'b1;
                    count_d = '0;
                    apply   = 1'b1;
                    if (oneshot_q) begin
                        active_d = 1'b0;
                    end
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end

            if (apply && pend_d) begin
                period_d  = sh_period_d;
                oneshot_d = sh_oneshot_d;
                pend_d    = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                count_q      <= '0;
                period_q     <= DEF_P;
                sh_period_q  <= DEF_P;
                oneshot_q    <= 1'b0;
                sh_oneshot_q <= 1'b0;
                pend_q       <= 1'b0;
                active_q     <= 1'b0;
                tick_q       <= 1'b0;
            end else begin
                count_q      <= count_d;
                period_q     <= period_d;
                sh_period_q  <= sh_period_d;
                oneshot_q    <= oneshot_d;
                sh_oneshot_q <= sh_oneshot_d;
                pend_q       <= pend_d;
                active_q     <= active_d;
                tick_q       <= tick_d;
            end
        end

        assign tick[i]   = tick_q;
        assign active[i] = active_q;
    end

endmodule
